// File: rtl/axi_stream_1_to_2_router_if.sv
// AXI Stream bundle shared by the router input and both router outputs.
// The master drives the payload and tvalid. The slave drives tready.
interface axi_stream_1_to_2_router_if #(
  parameter int AXIS_BUS_WIDTH   = 64,
  parameter int AXIS_TID_WIDTH   = 2,
  parameter int AXIS_TDEST_WIDTH = 2,
  parameter int AXIS_TUSER_WIDTH = 1
);
  localparam int KEEP_W = AXIS_BUS_WIDTH / 8;

  logic [AXIS_BUS_WIDTH-1:0]   tdata;
  logic [KEEP_W-1:0]           tkeep;
  logic [AXIS_TID_WIDTH-1:0]   tid;
  logic [AXIS_TDEST_WIDTH-1:0] tdest;
  logic [AXIS_TUSER_WIDTH-1:0] tuser;
  logic                        tlast;
  logic                        tvalid;
  logic                        tready;

  modport master (
    output tdata, tkeep, tid, tdest, tuser, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tid, tdest, tuser, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/axi_stream_1_to_2_router.sv
// Packet-level AXI Stream router with one input and two outputs.
// The route is taken from tdest on the first beat of a packet. It stays locked
// until tlast. Packets with tdest >= 2 are accepted and discarded, and each one
// adds one to a saturating counter. A single hold register is shared by both
// outputs, so every routed beat appears on its output one cycle after it is
// accepted.
module axi_stream_1_to_2_router #(
  parameter int AXIS_BUS_WIDTH   = 64,
  parameter int AXIS_TID_WIDTH   = 2,
  parameter int AXIS_TDEST_WIDTH = 2,
  parameter int AXIS_TUSER_WIDTH = 1,
  parameter int DROP_CNT_WIDTH   = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  axi_stream_1_to_2_router_if.slave  axis_in,
  axi_stream_1_to_2_router_if.master axis_out_0,
  axi_stream_1_to_2_router_if.master axis_out_1,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);
  localparam int KEEP_W = AXIS_BUS_WIDTH / 8;
  localparam logic [AXIS_TDEST_WIDTH-1:0] TDEST_ONE = AXIS_TDEST_WIDTH'(1);

  typedef enum logic {PKT_IDLE, PKT_BODY} pkt_state_t;
  typedef enum logic [1:0] {ROUTE_0 = 2'd0, ROUTE_1 = 2'd1, ROUTE_DROP = 2'd2} route_t;

  pkt_state_t pkt_state_q, pkt_state_d;
  route_t     route_q, route_d;
  route_t     sel;

  logic                        vld_p1;
  logic                        sel_p1;
  logic [AXIS_BUS_WIDTH-1:0]   tdata_p1;
  logic [KEEP_W-1:0]           tkeep_p1;
  logic [AXIS_TID_WIDTH-1:0]   tid_p1;
  logic [AXIS_TDEST_WIDTH-1:0] tdest_p1;
  logic [AXIS_TUSER_WIDTH-1:0] tuser_p1;
  logic                        tlast_p1;

  logic out_ready_sel;
  logic reg_free;
  logic accept;

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
    if (v == {DROP_CNT_WIDTH{1'b1}}) return v;
    return v + DROP_CNT_WIDTH'(1);
  endfunction

  // A first beat decodes tdest. A later beat reuses the locked route and ignores its tdest.
  always_comb begin
    sel = route_q;
    if (pkt_state_q == PKT_IDLE) begin
      if (axis_in.tdest == '0)           sel = ROUTE_0;
      else if (axis_in.tdest == TDEST_ONE) sel = ROUTE_1;
      else                                 sel = ROUTE_DROP;
    end
  end

  // The register can take a new beat when it is empty or when its selected output takes the beat now.
  // tready does not depend on the input tvalid.
  assign out_ready_sel   = sel_p1 ? axis_out_1.tready : axis_out_0.tready;
  assign reg_free        = !vld_p1 || out_ready_sel;
  assign axis_in.tready  = aresetn && reg_free;
  assign accept          = axis_in.tvalid && axis_in.tready;

  // Next packet state: lock the route after a non-last beat, and return to idle on tlast.
  always_comb begin
    pkt_state_d = pkt_state_q;
    route_d     = route_q;
    if (accept) begin
      if (axis_in.tlast) begin
        pkt_state_d = PKT_IDLE;
      end else begin
        pkt_state_d = PKT_BODY;
        route_d     = sel;
      end
    end
  end

  // Packet tracking registers. An asynchronous reset drops any partial packet.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_state_q <= PKT_IDLE;
      route_q     <= ROUTE_0;
    end else begin
      pkt_state_q <= pkt_state_d;
      route_q     <= route_d;
    end
  end

  // ---- stage p1: the hold register shared by both outputs ----
  // Load a routed beat. When a beat is dropped or nothing is accepted, the register only drains.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p1   <= 1'b0;
      sel_p1   <= 1'b0;
      tdata_p1 <= '0;
      tkeep_p1 <= '0;
      tid_p1   <= '0;
      tdest_p1 <= '0;
      tuser_p1 <= '0;
      tlast_p1 <= 1'b0;
    end else if (accept && sel != ROUTE_DROP) begin
      vld_p1   <= 1'b1;
      sel_p1   <= (sel == ROUTE_1);
      tdata_p1 <= axis_in.tdata;
      tkeep_p1 <= axis_in.tkeep;
      tid_p1   <= axis_in.tid;
      tdest_p1 <= axis_in.tdest;
      tuser_p1 <= axis_in.tuser;
      tlast_p1 <= axis_in.tlast;
    end else if (accept) begin
      vld_p1 <= vld_p1 && !out_ready_sel;
    end else if (reg_free) begin
      vld_p1 <= 1'b0;
    end
  end

  // Count dropped packets once each, on their first beat. The counter stops at its maximum.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drop_count <= '0;
    end else if (accept && sel == ROUTE_DROP && pkt_state_q == PKT_IDLE) begin
      drop_count <= sat_inc(drop_count);
    end
  end

  assign axis_out_0.tvalid = vld_p1 && !sel_p1;
  assign axis_out_1.tvalid = vld_p1 && sel_p1;

  assign axis_out_0.tdata  = tdata_p1;
  assign axis_out_0.tkeep  = tkeep_p1;
  assign axis_out_0.tid    = tid_p1;
  assign axis_out_0.tdest  = tdest_p1;
  assign axis_out_0.tuser  = tuser_p1;
  assign axis_out_0.tlast  = tlast_p1;

  assign axis_out_1.tdata  = tdata_p1;
  assign axis_out_1.tkeep  = tkeep_p1;
  assign axis_out_1.tid    = tid_p1;
  assign axis_out_1.tdest  = tdest_p1;
  assign axis_out_1.tuser  = tuser_p1;
  assign axis_out_1.tlast  = tlast_p1;
endmodule

// File: tb/tb_axi_stream_1_to_2_router.sv
// Directed bench for axi_stream_1_to_2_router.
// The main instance uses the default parameters. A second instance has a
// 2-bit drop counter so that counter saturation can be reached.
module tb_axi_stream_1_to_2_router;
  logic aclk;
  logic aresetn;
  logic [15:0] drop_count;
  logic [1:0]  drop_count_s;
  int total = 0;
  int bad   = 0;

  axi_stream_1_to_2_router_if in_if ();
  axi_stream_1_to_2_router_if o0_if ();
  axi_stream_1_to_2_router_if o1_if ();
  axi_stream_1_to_2_router_if in_s ();
  axi_stream_1_to_2_router_if o0_s ();
  axi_stream_1_to_2_router_if o1_s ();

  axi_stream_1_to_2_router dut (
    .aclk(aclk), .aresetn(aresetn),
    .axis_in(in_if), .axis_out_0(o0_if), .axis_out_1(o1_if),
    .drop_count(drop_count)
  );

  axi_stream_1_to_2_router #(.DROP_CNT_WIDTH(2)) dut_s (
    .aclk(aclk), .aresetn(aresetn),
    .axis_in(in_s), .axis_out_0(o0_s), .axis_out_1(o1_s),
    .drop_count(drop_count_s)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then move 1 time unit past it so outputs are read away from the edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [1:0] dest, input logic last);
    in_if.tvalid = v;
    in_if.tdata  = d;
    in_if.tdest  = dest;
    in_if.tlast  = last;
    in_if.tkeep  = 8'hFF;
    in_if.tid    = 2'd1;
    in_if.tuser  = 1'b1;
  endtask

  initial begin
    aresetn = 1'b0;
    drive(1'b0, 64'h0, 2'd0, 1'b0);
    o0_if.tready = 1'b1;
    o1_if.tready = 1'b1;
    in_s.tvalid = 1'b0; in_s.tdata = '0; in_s.tkeep = '0; in_s.tid = '0;
    in_s.tdest = '0; in_s.tuser = '0; in_s.tlast = 1'b0;
    o0_s.tready = 1'b1;
    o1_s.tready = 1'b1;

    // Reset state
    #1;
    chk("rst_in_tready", 64'(in_if.tready), 64'd0);
    chk("rst_out0_tvalid", 64'(o0_if.tvalid), 64'd0);
    chk("rst_out1_tvalid", 64'(o1_if.tvalid), 64'd0);
    chk("rst_out_tdata", o0_if.tdata, 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    step(); step();
    aresetn = 1'b1;
    #1;
    chk("post_rst_in_tready", 64'(in_if.tready), 64'd1);

    // 1: a 4-beat packet with tdest=1 appears on out1 in the cycle after each beat is accepted
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'hA100_0000_0000_0000 + 64'(i), 2'd1, i == 3);
      step();
      chk("t1_out1_tvalid", 64'(o1_if.tvalid), 64'd1);
      chk("t1_out1_tdata", o1_if.tdata, 64'hA100_0000_0000_0000 + 64'(i));
      chk("t1_out1_tlast", 64'(o1_if.tlast), (i == 3) ? 64'd1 : 64'd0);
      chk("t1_out0_tvalid", 64'(o0_if.tvalid), 64'd0);
    end
    drive(1'b0, 64'h0, 2'd0, 1'b0);
    step();
    chk("t1_out1_idle", 64'(o1_if.tvalid), 64'd0);

    // 2: the route is locked. tdest changes to 1 on later beats, and every beat still goes to out0
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'hB200_0000_0000_0000 + 64'(i), (i == 0) ? 2'd0 : 2'd1, i == 2);
      step();
      chk("t2_out0_tvalid", 64'(o0_if.tvalid), 64'd1);
      chk("t2_out0_tdata", o0_if.tdata, 64'hB200_0000_0000_0000 + 64'(i));
      chk("t2_out0_tdest", 64'(o0_if.tdest), (i == 0) ? 64'd0 : 64'd1);
      chk("t2_out1_tvalid", 64'(o1_if.tvalid), 64'd0);
    end
    drive(1'b0, 64'h0, 2'd0, 1'b0);
    step();

    // 3: two 3-beat packets with tdest 2 and 3 are dropped at 1 beat/cycle
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 64'hC300_0000_0000_0000 + 64'(i), (i < 3) ? 2'd2 : 2'd3, (i == 2) || (i == 5));
      #1;
      chk("t3_in_tready", 64'(in_if.tready), 64'd1);
      step();
      chk("t3_out0_tvalid", 64'(o0_if.tvalid), 64'd0);
      chk("t3_out1_tvalid", 64'(o1_if.tvalid), 64'd0);
    end
    drive(1'b0, 64'h0, 2'd0, 1'b0);
    step();
    chk("t3_drop_count", 64'(drop_count), 64'd2);

    // 4: out0 stalls for 5 cycles while out1 is ready. Data must stay stable and no beat may be lost
    o0_if.tready = 1'b0;
    drive(1'b1, 64'hD400_0000_0000_0000, 2'd0, 1'b0);
    #1;
    chk("t4_first_tready", 64'(in_if.tready), 64'd1);
    step();
    drive(1'b1, 64'hD400_0000_0000_0001, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_in_tready", 64'(in_if.tready), 64'd0);
      chk("t4_stall_out0_tvalid", 64'(o0_if.tvalid), 64'd1);
      chk("t4_stall_out0_tdata", o0_if.tdata, 64'hD400_0000_0000_0000);
      step();
    end
    o0_if.tready = 1'b1;
    #1;
    chk("t4_resume_in_tready", 64'(in_if.tready), 64'd1);
    step();
    chk("t4_beat1_tdata", o0_if.tdata, 64'hD400_0000_0000_0001);
    drive(1'b1, 64'hD400_0000_0000_0002, 2'd0, 1'b1);
    step();
    chk("t4_beat2_tdata", o0_if.tdata, 64'hD400_0000_0000_0002);
    chk("t4_beat2_tlast", 64'(o0_if.tlast), 64'd1);
    chk("t4_out1_tvalid", 64'(o1_if.tvalid), 64'd0);
    drive(1'b0, 64'h0, 2'd0, 1'b0);
    step();
    chk("t4_out0_idle", 64'(o0_if.tvalid), 64'd0);

    // 6: reset in the middle of a packet to out1. The next packet with tdest=0 must go to out0
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'hE600_0000_0000_0000 + 64'(i), 2'd1, 1'b0);
      step();
    end
    chk("t6_pre_out1_tvalid", 64'(o1_if.tvalid), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("t6_rst_out1_tvalid", 64'(o1_if.tvalid), 64'd0);
    chk("t6_rst_tdata", o1_if.tdata, 64'd0);
    chk("t6_rst_in_tready", 64'(in_if.tready), 64'd0);
    chk("t6_rst_drop_count", 64'(drop_count), 64'd0);
    step();
    aresetn = 1'b1;
    drive(1'b1, 64'hE600_0000_0000_00FF, 2'd0, 1'b1);
    step();
    chk("t6_new_out0_tvalid", 64'(o0_if.tvalid), 64'd1);
    chk("t6_new_out0_tdata", o0_if.tdata, 64'hE600_0000_0000_00FF);
    chk("t6_new_out1_tvalid", 64'(o1_if.tvalid), 64'd0);
    drive(1'b0, 64'h0, 2'd0, 1'b0);
    step();

    // 5: five dropped single-beat packets; the 2-bit counter stops at 3
    in_s.tvalid = 1'b1;
    in_s.tdest  = 2'd2;
    in_s.tlast  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_drop_count_sat", 64'(drop_count_s), (i < 3) ? 64'(i + 1) : 64'd3);
      chk("t5_out_tvalid", 64'(o0_s.tvalid | o1_s.tvalid), 64'd0);
    end
    in_s.tvalid = 1'b0;
    step();
    chk("t5_final_drop_count", 64'(drop_count_s), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
